// File: rtl/status_uplink.sv
// status_uplink: periodic / on-demand status frame transmitter for the
// FT245 TX side. Snapshots sample FIFO state and event counters, then
// streams a fixed frame byte-by-byte over a valid/ready handshake.
// Optional feature macro: UPLINK_CHECKSUM_EN appends a byte-7 XOR checksum;
// without it the frame is 7 bytes and no checksum logic is built.

module status_uplink #(
    parameter int REPORT_PERIOD = 1280000,
    parameter int LEVEL_WIDTH   = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LEVEL_WIDTH-1:0] fifo_level,
    input  logic                   fifo_empty,
    input  logic                   fifo_full,
    input  logic                   read_sample,
    input  logic                   rx_valid_si,
    input  logic                   req,
    output logic [7:0]             tx_data_si,
    output logic                   tx_valid_si,
    input  logic                   tx_ready_si,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    localparam logic [31:0] PERIOD_LAST = 32'(REPORT_PERIOD - 1);

`ifdef UPLINK_CHECKSUM_EN
    localparam int          NBYTES   = 8;
    localparam logic [2:0]  LAST_IDX = 3'd7;
`else
    localparam int          NBYTES   = 7;
    localparam logic [2:0]  LAST_IDX = 3'd6;
`endif

    state_t      state;
    logic [31:0] period_cnt;
    logic        pending;
    logic [7:0]  seq;
    logic [7:0]  ur_cnt;
    logic [7:0]  ov_cnt;
    logic        ur_seen;
    logic        ov_seen;
    logic [2:0]  idx;
    logic [7:0]  frame [NBYTES];
    logic [7:0]  snap  [NBYTES];
    logic [15:0] level_ext;
    logic        ur_ev;
    logic        ov_ev;
    logic        period_wrap;
    logic        trigger;

    assign ur_ev       = read_sample & fifo_empty;
    assign ov_ev       = rx_valid_si & fifo_full;
    assign period_wrap = (period_cnt == PERIOD_LAST);
    assign trigger     = req | period_wrap;

    // Frame contents as they would be captured if this were the LOAD cycle
    always_comb begin
        level_ext = 16'(fifo_level);
        snap[0]   = 8'hA5;
        snap[1]   = seq;
        snap[2]   = level_ext[15:8];
        snap[3]   = level_ext[7:0];
        snap[4]   = {4'b0000, ov_seen, ur_seen, fifo_full, fifo_empty};
        snap[5]   = ur_cnt;
        snap[6]   = ov_cnt;
`ifdef UPLINK_CHECKSUM_EN
        snap[7]   = seq ^ level_ext[15:8] ^ level_ext[7:0] ^
                    {4'b0000, ov_seen, ur_seen, fifo_full, fifo_empty} ^
                    ur_cnt ^ ov_cnt;
`endif
    end

    // Free-running report period counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (period_wrap) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 32'd1;
        end
    end

    // Single-entry report queue; a trigger during LOAD re-arms it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else begin
            pending <= trigger | (pending & (state != LOAD));
        end
    end

    // Saturating event counters and sticky flags, restarted at each snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ur_cnt  <= '0;
            ov_cnt  <= '0;
            ur_seen <= 1'b0;
            ov_seen <= 1'b0;
        end else if (state == LOAD) begin
            ur_cnt  <= {7'd0, ur_ev};
            ov_cnt  <= {7'd0, ov_ev};
            ur_seen <= ur_ev;
            ov_seen <= ov_ev;
        end else begin
            if (ur_ev && ur_cnt != 8'hFF) begin
                ur_cnt <= ur_cnt + 8'd1;
            end
            if (ov_ev && ov_cnt != 8'hFF) begin
                ov_cnt <= ov_cnt + 8'd1;
            end
            ur_seen <= ur_seen | ur_ev;
            ov_seen <= ov_seen | ov_ev;
        end
    end

    // Frame sequencer: capture snapshot, then stream bytes with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            seq         <= '0;
            tx_data_si  <= '0;
            tx_valid_si <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                frame[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pending || trigger) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        frame[i] <= snap[i];
                    end
                    idx         <= '0;
                    tx_data_si  <= snap[0];
                    tx_valid_si <= 1'b1;
                    state       <= SEND;
                end
                SEND: begin
                    if (tx_ready_si) begin
                        if (idx == LAST_IDX) begin
                            state       <= IDLE;
                            tx_valid_si <= 1'b0;
                            tx_data_si  <= '0;
                            busy        <= 1'b0;
                            seq         <= seq + 8'd1;
                        end else begin
                            idx        <= idx + 3'd1;
                            tx_data_si <= frame[idx + 3'd1];
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    tx_valid_si <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_status_uplink.sv
// tb_status_uplink: scoreboard bench for status_uplink. Directed scenarios
// push hand-computed frames into a queue; a negedge monitor pops and checks
// every accepted byte (value and cycle), plus stall stability. A second
// instance with a short report period checks periodic frame spacing.

module tb_status_uplink;

`ifdef UPLINK_CHECKSUM_EN
    localparam int NB = 8;
`else
    localparam int NB = 7;
`endif

    logic        clk;
    logic        rst;
    logic [10:0] fifo_level;
    logic        fifo_empty;
    logic        fifo_full;
    logic        read_sample;
    logic        rx_valid_si;
    logic        req;
    logic [7:0]  tx_data_si;
    logic        tx_valid_si;
    logic        tx_ready_si;
    logic        busy;

    logic [10:0] per_level;
    logic        per_zero;
    logic        per_ready;
    logic [7:0]  per_data;
    logic        per_valid;
    logic        per_busy;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic       stall_pending = 1'b0;
    logic [7:0] stall_data    = 8'h00;
    logic       per_valid_d   = 1'b0;
    logic       per_grab_seq  = 1'b0;
    int         per_frames    = 0;
    int         per_last      = 0;

    status_uplink u_dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_level  (fifo_level),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .read_sample (read_sample),
        .rx_valid_si (rx_valid_si),
        .req         (req),
        .tx_data_si  (tx_data_si),
        .tx_valid_si (tx_valid_si),
        .tx_ready_si (tx_ready_si),
        .busy        (busy)
    );

    status_uplink #(
        .REPORT_PERIOD (32),
        .LEVEL_WIDTH   (11)
    ) u_per (
        .clk         (clk),
        .rst         (rst),
        .fifo_level  (per_level),
        .fifo_empty  (per_zero),
        .fifo_full   (per_zero),
        .read_sample (per_zero),
        .rx_valid_si (per_zero),
        .req         (per_zero),
        .tx_data_si  (per_data),
        .tx_valid_si (per_valid),
        .tx_ready_si (per_ready),
        .busy        (per_busy)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter, zero while reset is held
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the bytes of one frame; bytes at or after stall_at slip by stall_len cycles
    task automatic expectFrame(input logic [7:0] s, input logic [15:0] lvl,
                               input logic [7:0] flags, input logic [7:0] ur,
                               input logic [7:0] ov, input int start,
                               input int nbytes, input int stall_at,
                               input int stall_len);
        logic [7:0] b [8];
        exp_t       e;
        b[0] = 8'hA5;
        b[1] = s;
        b[2] = lvl[15:8];
        b[3] = lvl[7:0];
        b[4] = flags;
        b[5] = ur;
        b[6] = ov;
        b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
        for (int i = 0; i < nbytes && i < NB; i++) begin
            e.data = b[i];
            e.cyc  = start + i + ((i >= stall_at) ? stall_len : 0);
            sb.push_back(e);
        end
    endtask

    // One-cycle report request issued in the current cycle
    task automatic applyStimulus();
        req = 1'b1;
        step(1);
        req = 1'b0;
    endtask

    // Wait, bounded, for every queued byte to be seen
    task automatic drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) begin
            step(1);
        end
        step(1);
        checkOutput("drain_empty", sb.size(), 0);
    endtask

    // Monitor: scoreboard pop on every accepted byte, stall stability, periodic instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (stall_pending) begin
                checkOutput("stall_valid", {31'd0, tx_valid_si}, 1);
                checkOutput("stall_data", {24'd0, tx_data_si}, {24'd0, stall_data});
            end
            if (tx_valid_si && tx_ready_si) begin
                checkOutput("sb_has_entry", {31'd0, sb.size() != 0}, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput("frame_byte", {24'd0, tx_data_si}, {24'd0, e.data});
                    checkOutput("byte_cycle", cyc, e.cyc);
                end
            end
            stall_pending = tx_valid_si && !tx_ready_si;
            stall_data    = tx_data_si;

            if (per_frames < 3) begin
                if (per_valid && !per_valid_d) begin
                    checkOutput("per_sync", {24'd0, per_data}, 32'hA5);
                    if (per_frames > 0) begin
                        checkOutput("per_spacing", cyc - per_last, 32);
                    end
                    per_last     = cyc;
                    per_grab_seq = 1'b1;
                end else if (per_grab_seq && per_valid) begin
                    checkOutput("per_seq", {24'd0, per_data}, per_frames);
                    per_frames++;
                    per_grab_seq = 1'b0;
                end
                per_valid_d = per_valid;
            end
        end else begin
            stall_pending = 1'b0;
        end
    end

    // Hang guard
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        int rc;
        rst         = 1'b1;
        fifo_level  = '0;
        fifo_empty  = 1'b0;
        fifo_full   = 1'b0;
        read_sample = 1'b0;
        rx_valid_si = 1'b0;
        req         = 1'b0;
        tx_ready_si = 1'b1;
        per_level   = 11'h000;
        per_zero    = 1'b0;
        per_ready   = 1'b1;
        step(3);
        checkOutput("reset_valid", {31'd0, tx_valid_si}, 0);
        checkOutput("reset_data", {24'd0, tx_data_si}, 0);
        checkOutput("reset_busy", {31'd0, busy}, 0);
        rst = 1'b0;

        // Basic frame, request at cycle 10
        fifo_level = 11'h155;
        while (cyc < 10) step(1);
        checkOutput("idle_busy", {31'd0, busy}, 0);
        rc = cyc;
        expectFrame(8'h00, 16'h0155, 8'h00, 8'h00, 8'h00, rc + 2, NB, 99, 0);
        applyStimulus();
        checkOutput("load_busy", {31'd0, busy}, 1);
        checkOutput("load_valid", {31'd0, tx_valid_si}, 0);
        step(NB + 1);
        checkOutput("end_busy", {31'd0, busy}, 0);
        checkOutput("end_valid", {31'd0, tx_valid_si}, 0);
        drain(20);

        // Three-cycle stall on byte 3
        step(2);
        rc = cyc;
        expectFrame(8'h01, 16'h0155, 8'h00, 8'h00, 8'h00, rc + 2, NB, 3, 3);
        applyStimulus();
        step(4);
        tx_ready_si = 1'b0;
        step(3);
        tx_ready_si = 1'b1;
        drain(30);

        // Saturating underrun count and overflow count
        step(2);
        fifo_empty  = 1'b1;
        read_sample = 1'b1;
        step(300);
        read_sample = 1'b0;
        fifo_empty  = 1'b0;
        fifo_full   = 1'b1;
        rx_valid_si = 1'b1;
        step(2);
        rx_valid_si = 1'b0;
        fifo_full   = 1'b0;
        fifo_level  = 11'h2AB;
        step(1);
        rc = cyc;
        expectFrame(8'h02, 16'h02AB, 8'h0C, 8'hFF, 8'h02, rc + 2, NB, 99, 0);
        applyStimulus();
        drain(30);
        step(2);
        rc = cyc;
        expectFrame(8'h03, 16'h02AB, 8'h00, 8'h00, 8'h00, rc + 2, NB, 99, 0);
        applyStimulus();
        drain(30);

        // Overflow exactly in the LOAD cycle lands in the next frame
        step(2);
        fifo_level = 11'h7FF;
        rc = cyc;
        expectFrame(8'h04, 16'h07FF, 8'h02, 8'h00, 8'h00, rc + 2, NB, 99, 0);
        applyStimulus();
        fifo_full   = 1'b1;
        rx_valid_si = 1'b1;
        step(1);
        fifo_full   = 1'b0;
        rx_valid_si = 1'b0;
        drain(30);
        step(2);
        rc = cyc;
        expectFrame(8'h05, 16'h07FF, 8'h08, 8'h00, 8'h01, rc + 2, NB, 99, 0);
        applyStimulus();
        drain(30);

        // Two requests during SEND queue exactly one back-to-back frame
        step(2);
        rc = cyc;
        expectFrame(8'h06, 16'h07FF, 8'h00, 8'h00, 8'h00, rc + 2, NB, 99, 0);
        expectFrame(8'h07, 16'h07FF, 8'h00, 8'h00, 8'h00, rc + 4 + NB, NB, 99, 0);
        applyStimulus();
        step(2);
        applyStimulus();
        step(1);
        applyStimulus();
        while (cyc < rc + 2 + NB) step(1);
        checkOutput("b2b_idle_busy", {31'd0, busy}, 0);
        step(1);
        checkOutput("b2b_load_busy", {31'd0, busy}, 1);
        drain(40);
        step(20);

        // Reset during byte 4 abandons the frame
        step(2);
        rc = cyc;
        expectFrame(8'h08, 16'h07FF, 8'h00, 8'h00, 8'h00, rc + 2, 4, 99, 0);
        applyStimulus();
        step(5);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", {31'd0, tx_valid_si}, 0);
        checkOutput("midrst_data", {24'd0, tx_data_si}, 0);
        checkOutput("midrst_busy", {31'd0, busy}, 0);
        checkOutput("midrst_queue", sb.size(), 0);
        step(2);
        rst = 1'b0;
        step(3);
        rc = cyc;
        expectFrame(8'h00, 16'h07FF, 8'h00, 8'h00, 8'h00, rc + 2, NB, 99, 0);
        applyStimulus();
        drain(30);
        step(10);

        checkOutput("per_frames", per_frames, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_uplink.md
# status_uplink

Host-bound status reporter driving the TX side of the FT245 simple interface, which is unused by the sample download path. Snapshots FIFO fill level, full/empty flags and saturating underrun/overflow event counters, frames them into a fixed packet and streams it byte-by-byte with a valid/ready handshake. Sits beside the sample FIFO and modulator in the top level, feeding `tx_data_si`/`tx_valid_si`/`tx_ready_si` of the FT245 wrapper.

## Interface

Parameters:
- `REPORT_PERIOD`, 1280000: clocks between periodic reports (10 ms at 128 MHz); must be ≥ 16.
- `LEVEL_WIDTH`, 11: width of `fifo_level`; must be ≤ 16.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `fifo_level`  in  LEVEL_WIDTH  current sample FIFO occupancy.
- `fifo_empty`  in  1  sample FIFO empty flag.
- `fifo_full`  in  1  sample FIFO full flag.
- `read_sample`  in  1  modulator FIFO read strobe.
- `rx_valid_si`  in  1  host byte offered to the sample FIFO.
- `req`  in  1  single-cycle on-demand report request.
- `tx_data_si`  out  8  byte to the FT245 wrapper.
- `tx_valid_si`  out  1  `tx_data_si` valid.
- `tx_ready_si`  in  1  wrapper accepts the byte when high with valid.
- `busy`  out  1  frame in progress: LOAD or SEND.

## Operation

- Event counters, 8-bit, saturating at 255:
  - Underrun: `read_sample & fifo_empty`.
  - Overflow: `rx_valid_si & fifo_full`.
- Sticky flags: `ur_seen` and `ov_seen` set on the first event since the last snapshot.
- Period counter:
  - Free-runs 0..REPORT_PERIOD-1 and wraps.
  - Wrap sets `pending`. `req` also sets `pending`.
  - `pending` is a single bit, so at most one frame is queued. Further triggers while `pending` is already set are dropped.
- FSM states: IDLE, LOAD, SEND.
  - IDLE: if `pending`, go to LOAD.
  - LOAD (one cycle):
    - Snapshot `fifo_level`, the flags, both counters and both sticky flags into the frame registers.
    - Clear the counters and sticky flags.
    - Clear `pending`; a trigger arriving in this same cycle re-sets it.
    - Set byte index to 0; go to SEND.
  - SEND:
    - Present byte[idx] with `tx_valid_si`=1.
    - On `tx_valid_si & tx_ready_si`: advance idx. After the last byte, go to IDLE and increment `seq` (8-bit, wraps 255→0).
- Event during the LOAD cycle: counted into the next frame, not the current one. The counter restarts at 1 (or the sticky flag is set) instead of being cleared.
- Frame layout, bytes 0..7:
  - 0: 0xA5 sync.
  - 1: `seq`.
  - 2: level[15:8], zero-extended.
  - 3: level[7:0].
  - 4: flags — bit0 empty, bit1 full, bit2 `ur_seen`, bit3 `ov_seen`, bits7:4 = 0.
  - 5: underrun count.
  - 6: overflow count.
  - 7: checksum = XOR of bytes 1..6.
- Frame contents are frozen at LOAD. Input changes during SEND do not alter the bytes being sent.

## Timing

- Reset values: `tx_valid_si`=0, `tx_data_si`=0x00, `busy`=0, FSM=IDLE, `seq`=0, counters/flags/`pending`=0, period counter=0.
- Trigger latency: `req` at cycle N → `pending` at N+1 → LOAD at N+1 → `tx_valid_si`=1 with 0xA5 at N+2.
- Throughput: with `tx_ready_si` held high, one byte per cycle; an 8-byte frame completes in 8 SEND cycles.
- Back-to-back: if `pending` is set when the last byte is accepted, the next LOAD occurs one cycle after the return to IDLE.
- Handshake rules:
  - `tx_data_si` is stable while `tx_valid_si` is high and `tx_ready_si` is low.
  - `tx_valid_si` never drops before acceptance.
  - `tx_ready_si` is ignored while `tx_valid_si`=0.
- `busy`=1 exactly in LOAD and SEND.
- Reset asserted mid-frame: outputs go to reset values immediately. No partial frame resumes after reset.

## Configuration

- `UPLINK_CHECKSUM_EN`:
  - Defined: frame is 8 bytes including the byte-7 XOR checksum.
  - Undefined: frame is 7 bytes (0..6); the FSM returns to IDLE after byte 6 and the checksum logic is absent.

## Test plan

- Reset, `req` at cycle 10, `tx_ready_si`=1, `fifo_level`=0x155, `fifo_empty`=`fifo_full`=0, no events → bytes A5 00 01 55 00 00 00 54 on cycles 12..19; `busy` low at cycle 20.
- `tx_ready_si` low for 3 cycles on byte 3 → `tx_data_si`=0x55 held with `tx_valid_si`=1 through the stall; frame otherwise identical; `seq`=1 on the next frame.
- 300 underrun strobes plus 2 overflows before `req` → byte5=0xFF, byte6=0x02, flags=0x0C; next frame counters=0, flags=0x00 (assuming FIFO not empty/full).
- Overflow strobe asserted exactly in the LOAD cycle → current frame byte6=0x00; next frame byte6=0x01, flags bit3=1.
- `REPORT_PERIOD`=32, no `req`, `tx_ready_si`=1 → frames start every 32 cycles; `seq` goes 0,1,2; `req` during SEND queues exactly one extra frame.
- `rst` asserted during byte 4 → `tx_valid_si`=0 at once; after release plus `req`, the frame starts with A5 and `seq`=00.
